// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, constants and width helper for the keypad scanner
package keypad_pkg;

    typedef enum logic {
        ST_DRIVE = 1'b0,
        ST_GAP   = 1'b1
    } scan_state_e;

    localparam int KEY_NONE = 0;
    localparam int DB_CNT_W = 4;

    // Index width that never collapses to zero bits for a single-entry range
    function automatic int key_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad pins plus key event/level outputs, master = scanner side
interface keypad_scanner_if
    import keypad_pkg::*;
#(
    parameter int ROWS = 3,
    parameter int COLS = 3
) ();
    localparam int NKEYS = ROWS * COLS;
    localparam int KW    = key_w(NKEYS);

    logic [ROWS-1:0]  row_out;
    logic [COLS-1:0]  col_in;
    logic             key_valid;
    logic [KW-1:0]    key_code;
    logic [NKEYS-1:0] key_state;
    logic             scan_tick;

    modport master (
        output row_out, key_valid, key_code, key_state, scan_tick,
        input  col_in
    );

    modport slave (
        input  row_out, key_valid, key_code, key_state, scan_tick,
        output col_in
    );
endinterface

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - one key: agreement counter, stable level and press/release strobes
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = 3
) (
    input  logic hwclk,
    input  logic rst_n,
    input  logic en_i,
    input  logic sample_i,
    output logic stable_o,
    output logic press_o,
    output logic release_o
);
    logic [DB_CNT_W-1:0] cnt_q;
    logic                stable_q;
    logic                flip;

    assign flip      = en_i && (sample_i != stable_q) && (cnt_q == DB_CNT_W'(DEBOUNCE - 1));
    assign press_o   = flip && !stable_q;
    assign release_o = flip && stable_q;
    assign stable_o  = stable_q;

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else if (en_i) begin
            if (sample_i == stable_q) begin
                cnt_q <= '0;
            end else if (flip) begin
                stable_q <= ~stable_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - row-strobed matrix keypad scanner with debounce and press events
// Optional auto-repeat of held keys: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS     = 3,
    parameter int COLS     = 3,
    parameter int SCAN_DIV = 100,
    parameter int DEBOUNCE = 3,
    parameter int REPEAT   = 64
) (
    input  logic             hwclk,
    input  logic             rst_n,
    keypad_scanner_if.master kp
);
    localparam int NKEYS = ROWS * COLS;
    localparam int KW    = key_w(NKEYS);
    localparam int RW    = key_w(ROWS);
    localparam int DW    = key_w(SCAN_DIV);

    logic [1:0]       rst_sync_q;
    logic             rst_int_n;
    logic [DW-1:0]    div_q;
    logic             tick;
    scan_state_e      state_q, state_d;
    logic [RW-1:0]    row_q, row_d;
    logic [ROWS-1:0]  row_out_q;
    logic [COLS-1:0]  col_s1_q, col_s2_q;
    logic [NKEYS-1:0] samp_q;
    logic             frame_end;
    logic [NKEYS-1:0] stable, press, rel, rep_fire;
    logic [NKEYS-1:0] pending_q, pending_d;
    logic [KW-1:0]    issue_idx;
    logic             any_pending;
    logic             key_valid_q;
    logic [KW-1:0]    key_code_q;

    // Assert asynchronously, release two clocks after rst_n rises
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    assign tick = (div_q == DW'(SCAN_DIV - 1));

    always_ff @(posedge hwclk or negedge rst_int_n) begin
        if (!rst_int_n) div_q <= '0;
        else            div_q <= tick ? '0 : div_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        if (tick) begin
            if (state_q == ST_DRIVE) begin
                state_d = ST_GAP;
            end else begin
                state_d = ST_DRIVE;
                row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
            end
        end
    end

    always_ff @(posedge hwclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q   <= ST_DRIVE;
            row_q     <= '0;
            row_out_q <= '1;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            row_out_q <= (state_d == ST_DRIVE) ? ~(ROWS'(1) << row_d) : '1;
        end
    end

    // Columns idle high through pull-ups, so the synchroniser resets to all ones
    always_ff @(posedge hwclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            col_s1_q <= '1;
            col_s2_q <= '1;
            samp_q   <= '0;
        end else begin
            col_s1_q <= kp.col_in;
            col_s2_q <= col_s1_q;
            for (int r = 0; r < ROWS; r++) begin
                if (tick && state_q == ST_DRIVE && row_q == RW'(r))
                    samp_q[r*COLS +: COLS] <= ~col_s2_q;
            end
        end
    end

    // All keys debounce together at the end of the last gap, so keys seen in one frame flip together
    assign frame_end = tick && (state_q == ST_GAP) && (row_q == RW'(ROWS - 1));

    for (genvar k = 0; k < NKEYS; k++) begin : g_key
        keypad_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
            .hwclk     (hwclk),
            .rst_n     (rst_int_n),
            .en_i      (frame_end),
            .sample_i  (samp_q[k]),
            .stable_o  (stable[k]),
            .press_o   (press[k]),
            .release_o (rel[k])
        );
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPW = key_w(REPEAT);
    for (genvar k = 0; k < NKEYS; k++) begin : g_rep
        logic [RPW-1:0] rep_q;
        assign rep_fire[k] = frame_end && stable[k] && !rel[k] && (rep_q == RPW'(REPEAT - 1));
        always_ff @(posedge hwclk or negedge rst_int_n) begin
            if (!rst_int_n) begin
                rep_q <= '0;
            end else if (frame_end) begin
                if (!stable[k] || rel[k] || rep_fire[k]) rep_q <= '0;
                else                                     rep_q <= rep_q + 1'b1;
            end
        end
    end
`else
    assign rep_fire = '0;
`endif

    always_comb begin
        issue_idx   = KW'(KEY_NONE);
        any_pending = |pending_q;
        for (int k = NKEYS - 1; k >= 0; k--) begin
            if (pending_q[k]) issue_idx = KW'(k);
        end
        pending_d = pending_q;
        if (tick && any_pending) pending_d[issue_idx] = 1'b0;
        pending_d = (pending_d | press | rep_fire) & ~rel;
    end

    always_ff @(posedge hwclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            pending_q   <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= KW'(KEY_NONE);
        end else begin
            pending_q   <= pending_d;
            key_valid_q <= tick && any_pending;
            if (tick && any_pending) key_code_q <= issue_idx;
        end
    end

    assign kp.row_out   = row_out_q;
    assign kp.scan_tick = tick;
    assign kp.key_valid = key_valid_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_state = stable;
endmodule
